reg_shift_bank: RTL and testbench

//  Parametrised bank of NCH registers, each WIDTH bits, written by serial shift, parallel load or clear.

---
 rtl/reg_shift_pkg.sv | 17 +
 rtl/reg_shift_cell.sv | 45 ++++
 rtl/reg_shift_bank.sv | 137 +++++++++++++
 tb/tb_reg_shift_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reg_shift_pkg.sv
// Shared types for the channelised shift-register bank.
// Optional parity readback is enabled by defining SHIFT_BANK_PARITY_EN.
package reg_shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/reg_shift_cell.sv
// One WIDTH-bit channel register with shift / load / clear mode mux.
// d_o exposes the next-state value so the bank can register readback without extra latency.
module reg_shift_cell
  import reg_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  mode_t            mode_i,
  input  logic             in_i,
  input  logic [WIDTH-1:0] pdata_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] d_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) begin
      unique case (mode_i)
        MODE_HOLD:  q_d = q_q;
        MODE_SHIFT: q_d = {q_q[WIDTH-2:0], in_i};
        MODE_LOAD:  q_d = pdata_i;
        MODE_CLEAR: q_d = '0;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
  assign d_o = q_d;

endmodule

// File: rtl/reg_shift_bank.sv
// Bank of NCH shift/load registers with serial-frame tracking and registered readback.
// Define SHIFT_BANK_PARITY_EN to add the rpar parity output alongside rout.
module reg_shift_bank
  import reg_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic [WIDTH-1:0] pdata,
  input  logic [1:0]       ctrl,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] rout,
  output logic             busy,
  output logic             frame_done
`ifdef SHIFT_BANK_PARITY_EN
  ,
  output logic             rpar
`endif
);

  localparam int CNTW = $clog2(WIDTH + 1);

  mode_t            mode;
  logic             sel_valid;
  logic [NCH-1:0]   we;
  logic [WIDTH-1:0] ch_q [NCH];
  logic [WIDTH-1:0] ch_d [NCH];

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0]  tch_q, tch_d;
  logic             done_set;

  logic [WIDTH-1:0] rout_q, rout_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  assign mode      = mode_t'(ctrl);
  assign sel_valid = (32'(sel) < 32'(NCH));

  for (genvar g = 0; g < NCH; g++) begin : gen_ch
    assign we[g] = sel_valid && (32'(sel) == 32'(g));

    reg_shift_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (we[g]),
      .mode_i  (mode),
      .in_i    (in),
      .pdata_i (pdata),
      .q_o     (ch_q[g]),
      .d_o     (ch_d[g])
    );
  end

  // Frame tracking: only consecutive shifts into the same channel count toward a frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tch_d    = tch_q;
    done_set = 1'b0;
    if (sel_valid) begin
      unique case (mode)
        MODE_SHIFT: begin
          if (state_q == S_IDLE || sel != tch_q) begin
            state_d = S_SHIFT;
            cnt_d   = CNTW'(1);
            tch_d   = sel;
          end else if (cnt_q == CNTW'(WIDTH - 1)) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            done_set = 1'b1;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        MODE_LOAD, MODE_CLEAR: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_d       = (state_d == S_SHIFT);
    frame_done_d = done_set;
    rout_d       = rout_q;
    for (int i = 0; i < NCH; i++) begin
      if (we[i]) rout_d = ch_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tch_q        <= '0;
      rout_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tch_q        <= tch_d;
      rout_q       <= rout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rout       = rout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef SHIFT_BANK_PARITY_EN
  logic rpar_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rpar_q <= 1'b0;
    end else begin
      rpar_q <= ^rout_d;
    end
  end

  assign rpar = rpar_q;
`endif

endmodule

// File: tb/tb_reg_shift_bank.sv
// Scoreboard bench for reg_shift_bank (WIDTH=4, NCH=4) driven by hand-computed directed vectors.
module tb_reg_shift_bank;

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] LOAD  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic [3:0] pdata;
  logic [1:0] ctrl;
  logic [1:0] sel;
  logic [3:0] rout;
  logic       busy;
  logic       frame_done;
`ifdef SHIFT_BANK_PARITY_EN
  logic       rpar;
`endif

  typedef struct {
    int         step;
    logic [3:0] rout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  reg_shift_bank #(
    .WIDTH (4),
    .NCH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_bit),
    .pdata      (pdata),
    .ctrl       (ctrl),
    .sel        (sel),
    .rout       (rout),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef SHIFT_BANK_PARITY_EN
    ,
    .rpar       (rpar)
`endif
  );

  // Drive one cycle of stimulus and queue the response expected after the next edge.
  task automatic step(input logic r, input logic [1:0] c, input logic [1:0] s, input logic b,
                      input logic [3:0] p, input logic [3:0] e_rout, input logic e_busy,
                      input logic e_done);
    exp_t e;
    @(negedge clk);
    rst    = r;
    ctrl   = c;
    sel    = s;
    in_bit = b;
    pdata  = p;
    step_no++;
    e.step = step_no;
    e.rout = e_rout;
    e.busy = e_busy;
    e.done = e_done;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (rout !== e.rout) begin
        fails++;
        $display("FAIL step%0d rout: got %b want %b", e.step, rout, e.rout);
      end
      tests++;
      if (busy !== e.busy) begin
        fails++;
        $display("FAIL step%0d busy: got %b want %b", e.step, busy, e.busy);
      end
      tests++;
      if (frame_done !== e.done) begin
        fails++;
        $display("FAIL step%0d frame_done: got %b want %b", e.step, frame_done, e.done);
      end
`ifdef SHIFT_BANK_PARITY_EN
      tests++;
      if (rpar !== ^e.rout) begin
        fails++;
        $display("FAIL step%0d rpar: got %b want %b", e.step, rpar, ^e.rout);
      end
`endif
    end
  end

  initial begin
    rst = 1'b1; ctrl = HOLD; sel = 2'd0; in_bit = 1'b0; pdata = 4'h0;

    // Reset state
    step(1, HOLD, 0, 0, 4'h0, 4'b0000, 0, 0);
    step(1, HOLD, 0, 0, 4'h0, 4'b0000, 0, 0);

    // Reset mid-frame on ch1 (cnt=2, ch1=0011)
    step(0, SHIFT, 1, 1, 4'h0, 4'b0001, 1, 0);
    step(0, SHIFT, 1, 1, 4'h0, 4'b0011, 1, 0);
    step(1, SHIFT, 1, 1, 4'h0, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) step(0, HOLD, 2'(i), 0, 4'h0, 4'b0000, 0, 0);

    // Full frame 1,0,1,1 into ch2
    step(0, SHIFT, 2, 1, 4'h0, 4'b0001, 1, 0);
    step(0, SHIFT, 2, 0, 4'h0, 4'b0010, 1, 0);
    step(0, SHIFT, 2, 1, 4'h0, 4'b0101, 1, 0);
    step(0, SHIFT, 2, 1, 4'h0, 4'b1011, 0, 1);
    step(0, HOLD,  2, 0, 4'h0, 4'b1011, 0, 0);

    // Frame on ch0 with a 3-cycle gap
    step(0, SHIFT, 0, 1, 4'h0, 4'b0001, 1, 0);
    step(0, SHIFT, 0, 1, 4'h0, 4'b0011, 1, 0);
    step(0, HOLD,  0, 0, 4'h0, 4'b0011, 1, 0);
    step(0, HOLD,  0, 1, 4'h0, 4'b0011, 1, 0);
    step(0, HOLD,  0, 0, 4'h0, 4'b0011, 1, 0);
    step(0, SHIFT, 0, 0, 4'h0, 4'b0110, 1, 0);
    step(0, SHIFT, 0, 1, 4'h0, 4'b1101, 0, 1);
    step(0, HOLD,  0, 0, 4'h0, 4'b1101, 0, 0);

    // Abandoned frame on ch1, completed frame on ch3
    step(0, SHIFT, 1, 1, 4'h0, 4'b0001, 1, 0);
    step(0, SHIFT, 1, 1, 4'h0, 4'b0011, 1, 0);
    step(0, SHIFT, 3, 0, 4'h0, 4'b0000, 1, 0);
    step(0, SHIFT, 3, 1, 4'h0, 4'b0001, 1, 0);
    step(0, SHIFT, 3, 0, 4'h0, 4'b0010, 1, 0);
    step(0, SHIFT, 3, 1, 4'h0, 4'b0101, 0, 1);
    step(0, HOLD,  1, 0, 4'h0, 4'b0011, 0, 0);

    // LOAD on another channel aborts a frame; then CLEAR
    step(0, SHIFT, 1, 1, 4'h0, 4'b0111, 1, 0);
    step(0, SHIFT, 1, 0, 4'h0, 4'b1110, 1, 0);
    step(0, LOAD,  2, 0, 4'hA, 4'b1010, 0, 0);
    step(0, HOLD,  1, 0, 4'h0, 4'b1110, 0, 0);
    step(0, SHIFT, 1, 1, 4'h0, 4'b1101, 1, 0);
    step(0, HOLD,  1, 0, 4'h0, 4'b1101, 1, 0);
    step(0, CLEAR, 2, 0, 4'h0, 4'b0000, 0, 0);
    step(0, HOLD,  3, 0, 4'h0, 4'b0101, 0, 0);

    // Back-to-back frames on ch0 (ch0 starts at 1101)
    step(0, SHIFT, 0, 1, 4'h0, 4'b1011, 1, 0);
    step(0, SHIFT, 0, 0, 4'h0, 4'b0110, 1, 0);
    step(0, SHIFT, 0, 1, 4'h0, 4'b1101, 1, 0);
    step(0, SHIFT, 0, 0, 4'h0, 4'b1010, 0, 1);
    step(0, SHIFT, 0, 1, 4'h0, 4'b0101, 1, 0);
    step(0, SHIFT, 0, 1, 4'h0, 4'b1011, 1, 0);
    step(0, SHIFT, 0, 1, 4'h0, 4'b0111, 1, 0);
    step(0, SHIFT, 0, 1, 4'h0, 4'b1111, 0, 1);
    step(0, HOLD,  0, 0, 4'h0, 4'b1111, 0, 0);

    // Loads with odd and even parity
    step(0, LOAD,  3, 0, 4'h7, 4'b0111, 0, 0);
    step(0, LOAD,  3, 0, 4'h6, 4'b0110, 0, 0);
    step(0, HOLD,  2, 0, 4'h0, 4'b0000, 0, 0);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
